joypad_responder: RTL

JOYPAD_RESPONDER -- requirements
Module: joypad_responder

---
 rtl/joypad_responder_pkg.sv | 43 ++++
 rtl/jp_sync.sv | 42 ++++
 rtl/joypad_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/joypad_responder_pkg.sv
// rtl/joypad_responder_pkg.sv - shared joypad constants, button index enum and turbo gating helper
//
// Purpose : constants shared by the joypad responder and its sub-modules.
//           Button bit indices follow the console serial order (A first).
// Contents: JP_WIDTH   - serial report width in bits
//           btn_idx_t  - button bit indices BTN_A..BTN_RIGHT = 0..7
//           jp_bits_t  - one bit per button, 1 = pressed
//           apply_turbo- gates A/B with the turbo phase when turbo is enabled
`timescale 1ns/1ps

package joypad_responder_pkg;

    localparam int JP_WIDTH = 8;

    typedef enum logic [2:0] {
        BTN_A      = 3'd0,
        BTN_B      = 3'd1,
        BTN_SELECT = 3'd2,
        BTN_START  = 3'd3,
        BTN_UP     = 3'd4,
        BTN_DOWN   = 3'd5,
        BTN_LEFT   = 3'd6,
        BTN_RIGHT  = 3'd7
    } btn_idx_t;

    typedef logic [JP_WIDTH-1:0] jp_bits_t;

    // With turbo enabled a button only reports pressed while the phase is
    // high, so holding it produces a square wave of presses.
    function automatic jp_bits_t apply_turbo(
        input jp_bits_t deb,
        input logic     turbo_a,
        input logic     turbo_b,
        input logic     phase
    );
        jp_bits_t eff;
        eff        = deb;
        eff[BTN_A] = deb[BTN_A] & (~turbo_a | phase);
        eff[BTN_B] = deb[BTN_B] & (~turbo_b | phase);
        return eff;
    endfunction

endpackage

// File: rtl/jp_sync.sv
// rtl/jp_sync.sv - two-flop synchronizer with edge detector for one console input
//
// Purpose : brings one asynchronous console pin into the clk_in domain and
//           produces single-cycle rise/fall pulses from the synchronized level.
// Ports   : clk_in   - system clock
//           nrst_in  - asynchronous active-low reset
//           i_async  - asynchronous input pin
//           o_level  - synchronized level
//           o_rise   - one-cycle pulse on synchronized rising edge
//           o_fall   - one-cycle pulse on synchronized falling edge
`timescale 1ns/1ps

module jp_sync (
    input  logic clk_in,
    input  logic nrst_in,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/joypad_responder.sv
// rtl/joypad_responder.sv - console joypad emulator: debounce, turbo, latch/shift serial report
//
// Purpose : answers console joypad polls. Physical buttons are debounced,
//           A/B optionally turbo-gated, loaded into an 8-bit shift register
//           while latch is high and shifted out LSB first on jp_clk rises.
// Ports   : clk_in      - system clock
//           nrst_in     - asynchronous active-low reset
//           btn_in      - raw buttons, 1 = pressed, bit0 = A .. bit7 = Right
//           turbo_a_in  - turbo enable for A (level)
//           turbo_b_in  - turbo enable for B (level)
//           jp_clk_in   - console shift clock (asynchronous)
//           jp_latch_in - console latch (asynchronous, active high)
//           jp_data_out - serial data, 0 = pressed, 1 = not pressed / exhausted
//           poll_out    - one-cycle pulse per completed latch
`timescale 1ns/1ps

module joypad_responder
    import joypad_responder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int TURBO_DIV       = 1666666
) (
    input  logic                clk_in,
    input  logic                nrst_in,
    input  logic [JP_WIDTH-1:0] btn_in,
    input  logic                turbo_a_in,
    input  logic                turbo_b_in,
    input  logic                jp_clk_in,
    input  logic                jp_latch_in,
    output logic                jp_data_out,
    output logic                poll_out
);

    localparam int TICK_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int TURBO_W = $clog2(TURBO_DIV);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TURBO_W-1:0] TURBO_LAST = TURBO_W'(TURBO_DIV - 1);

    // ------------------------------------------------------------------
    // Console input synchronizers
    // ------------------------------------------------------------------
    logic w_clk_rise;
    logic w_latch_level;
    logic w_latch_fall;
    logic w_unused_clk_level;
    logic w_unused_clk_fall;
    logic w_unused_latch_rise;

    jp_sync u_sync_clk (
        .clk_in  (clk_in),
        .nrst_in (nrst_in),
        .i_async (jp_clk_in),
        .o_level (w_unused_clk_level),
        .o_rise  (w_clk_rise),
        .o_fall  (w_unused_clk_fall)
    );

    jp_sync u_sync_latch (
        .clk_in  (clk_in),
        .nrst_in (nrst_in),
        .i_async (jp_latch_in),
        .o_level (w_latch_level),
        .o_rise  (w_unused_latch_rise),
        .o_fall  (w_latch_fall)
    );

    // ------------------------------------------------------------------
    // Debounce sample tick
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a bit follows the input only once two consecutive samples
    // agree, so any glitch shorter than one tick period is rejected.
    // ------------------------------------------------------------------
    jp_bits_t r_prev_sample;
    jp_bits_t r_debounced;
    jp_bits_t w_agree;
    jp_bits_t w_deb_next;

    assign w_agree    = ~(btn_in ^ r_prev_sample);
    assign w_deb_next = (w_agree & btn_in) | (~w_agree & r_debounced);

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            r_prev_sample <= '0;
            r_debounced   <= '0;
        end else if (w_tick) begin
            r_prev_sample <= btn_in;
            r_debounced   <= w_deb_next;
        end
    end

    // ------------------------------------------------------------------
    // Turbo phase generator
    // ------------------------------------------------------------------
    logic [TURBO_W-1:0] r_turbo_cnt;
    logic               r_turbo_phase;
    logic               w_turbo_wrap;

    assign w_turbo_wrap = (r_turbo_cnt == TURBO_LAST);

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            r_turbo_cnt   <= '0;
            r_turbo_phase <= 1'b0;
        end else if (w_turbo_wrap) begin
            r_turbo_cnt   <= '0;
            r_turbo_phase <= ~r_turbo_phase;
        end else begin
            r_turbo_cnt   <= r_turbo_cnt + TURBO_W'(1);
        end
    end

    jp_bits_t w_effective;

    assign w_effective = apply_turbo(r_debounced, turbo_a_in, turbo_b_in, r_turbo_phase);

    // ------------------------------------------------------------------
    // Shift register. Latch high reloads every cycle, so clk edges during
    // latch are naturally ignored. A clk rise landing in the same cycle as
    // the latch fall is suppressed so the first bit is never skipped.
    // Zero fill makes every read past the eighth bit report not-pressed.
    // ------------------------------------------------------------------
    jp_bits_t r_shift;

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            r_shift <= '0;
        end else if (w_latch_level) begin
            r_shift <= w_effective;
        end else if (w_clk_rise && !w_latch_fall) begin
            r_shift <= {1'b0, r_shift[JP_WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic r_data_out;
    logic r_poll;

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            r_data_out <= 1'b1;
            r_poll     <= 1'b0;
        end else begin
            r_data_out <= ~r_shift[0];
            r_poll     <= w_latch_fall;
        end
    end

    assign jp_data_out = r_data_out;
    assign poll_out    = r_poll;

endmodule
